// File: rtl/cmip_toggle_evt_rx.sv
`default_nettype none
// ============================================================================
// Module      : cmip_toggle_evt_rx
// Description : Receive side of a toggle-based event crossing. Synchronizes a
//               foreign-domain request toggle, turns every transition into one
//               queued event, hands events out over valid/ready and returns an
//               acknowledge toggle per accepted event. Drops on a saturated
//               counter are flagged by a sticky overflow bit.
// Revision    : 1.0 - initial release
// ============================================================================
module cmip_toggle_evt_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req_tgl,
  output logic             o_evt_vld,
  input  logic             i_evt_rdy,
  output logic             o_ack_tgl,
  output logic [CNT_W-1:0] o_pending,
  output logic             o_ovf,
  input  logic             i_ovf_clr
);

  localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_req_p;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_vld;
  logic                   r_ack;
  logic                   r_ovf;

  logic                   w_req_s;
  logic                   w_evt_in;
  logic                   w_xfer;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_drop;

  // The oldest synchronizer stage is the settled request level; an event is
  // any difference between it and its value one cycle earlier.
  assign w_req_s  = r_sync[SYNC_STAGES-1];
  assign w_evt_in = w_req_s ^ r_req_p;
  assign w_xfer   = r_vld & i_evt_rdy;

  // Synchronizer chain and previous-level flop for edge detection.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync  <= '0;
      r_req_p <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_req_tgl};
      r_req_p <= w_req_s;
    end
  end

  // Next pending count: a simultaneous arrival and transfer cancel out, so a
  // full counter only drops when nothing leaves in the same cycle.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_drop    = 1'b0;
    if (w_evt_in && !w_xfer) begin
      if (r_cnt == c_CNT_MAX) begin
        w_drop = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + c_CNT_ONE;
      end
    end else if (!w_evt_in && w_xfer) begin
      w_cnt_nxt = r_cnt - c_CNT_ONE;
    end
  end

  // Counter, registered valid, acknowledge toggle and sticky overflow.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= c_CNT_ZERO;
      r_vld <= 1'b0;
      r_ack <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_vld <= (w_cnt_nxt != c_CNT_ZERO);
      if (w_xfer) begin
        r_ack <= ~r_ack;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (i_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign o_evt_vld = r_vld;
  assign o_pending = r_cnt;
  assign o_ack_tgl = r_ack;
  assign o_ovf     = r_ovf;

endmodule
`default_nettype wire

// File: doc/cmip_toggle_evt_rx.md
# cmip_toggle_evt_rx

Receiving end of the toggle-based event channel used between clock domains: accepts a level-toggle request from a foreign domain, synchronizes it into `i_clk`, and converts each toggle into one queued event. Events go to local logic over a valid/ready handshake, and each accepted event is returned as an acknowledge toggle. It sits at the destination side of control/trigger crossings where the consumer can stall and events must not be silently merged.

## Interface
- `SYNC_STAGES`, 2, synchronizer depth for `i_req_tgl`; legal range 2..4.
- `CNT_W`, 4, width of the pending-event counter; capacity is 2^CNT_W-1 events.

- `i_clk`  in  1  single clock for all logic.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_req_tgl`  in  1  request toggle from the foreign domain; asynchronous to `i_clk`; every transition (0->1 or 1->0) is one event.
- `o_evt_vld`  out  1  at least one event is pending.
- `i_evt_rdy`  in  1  consumer accepts the event; a transfer occurs when `o_evt_vld && i_evt_rdy`.
- `o_ack_tgl`  out  1  toggles once per transfer; returned to the sender domain.
- `o_pending`  out  CNT_W  current pending-event count.
- `o_ovf`  out  1  sticky flag: an event was dropped because the counter was saturated.
- `i_ovf_clr`  in  1  single-cycle pulse that clears `o_ovf`.

## Operation
- Synchronizer: a chain of `SYNC_STAGES` flops samples `i_req_tgl`. The last stage is `req_s`. A further flop `req_p` holds the previous `req_s`.
- Event detect: `evt_in = req_s ^ req_p`. This is combinational from registers only.
- Pending counter `cnt` (CNT_W bits); `xfer = o_evt_vld & i_evt_rdy`.
  - `evt_in` only, `cnt < max`: `cnt+1`.
  - `evt_in` only, `cnt == max`: `cnt` unchanged, event dropped, `o_ovf` <= 1.
  - `xfer` only: `cnt-1`.
  - `evt_in` and `xfer` together: `cnt` unchanged, no overflow, even when `cnt == max`.
  - Neither: hold.
- `o_evt_vld = (cnt != 0)`. It is driven from a register, so there is no combinational path from `i_evt_rdy` or `i_req_tgl`. `o_pending = cnt`.
- `o_ack_tgl` inverts on every cycle in which `xfer` is 1.
- `o_ovf`: set on a drop and cleared by `i_ovf_clr`. If a set and a clear occur in the same cycle, the set wins.
- Sender contract: `i_req_tgl` must hold each level for at least `SYNC_STAGES+1` `i_clk` periods. Faster toggling is outside the contract; events may merge.
- Counter arithmetic never wraps: no increment above 2^CNT_W-1 and no decrement below 0. A decrement at 0 is impossible because `xfer` requires `cnt != 0`.

## Timing
- Reset (synchronous, `i_rst_n == 0` at a rising edge): clears all synchronizer stages, `req_p`, `cnt`, `o_ack_tgl` and `o_ovf` to 0. Therefore `o_evt_vld = 0` and `o_pending = 0`.
- Reset has priority over every other update. Asserting reset mid-operation discards all pending events and the overflow flag at that edge.
- After reset release, a `i_req_tgl` level of 1 propagates as a 0->1 transition and counts as one event. The sender resets its toggle to 0 together with this block.
- Latency: `i_req_tgl` changes before rising edge N (first capture at N). Then `evt_in` is high during the cycle after edge N+SYNC_STAGES-1, and `cnt` increments at edge N+SYNC_STAGES. `o_evt_vld` is high from edge N+SYNC_STAGES (edge N+2 for the default).
- A transfer at edge M: `cnt` decrements at M and `o_ack_tgl` flips at M.
- Back-to-back transfers are allowed: with `i_evt_rdy` held high and `cnt = k`, exactly k consecutive cycles carry `o_evt_vld`.

## Test plan
- Single event, `SYNC_STAGES=2`, `i_evt_rdy=1`: toggle `i_req_tgl` 0->1 before edge 10 -> `o_evt_vld` high for exactly one cycle starting at edge 12; `o_ack_tgl` 0->1 at edge 13; `o_pending` returns to 0.
- Stalled burst: `i_evt_rdy=0`; three toggles spaced 4 cycles apart -> `o_pending=3`, `o_ack_tgl` unchanged. Then raise `i_evt_rdy` -> 3 consecutive transfer cycles, `o_ack_tgl` flips 3 times and ends at 1, `o_pending=0`.
- Saturation, `CNT_W=2`, `i_evt_rdy=0`: five toggles -> `o_pending=3`, `o_ovf=1` after the fourth toggle. Then `i_ovf_clr` pulse -> `o_ovf=0`. Then drain -> exactly 3 transfers.
- Simultaneous edge and transfer at full, `CNT_W=2`, `cnt=3`: raise `i_evt_rdy` in the same cycle `evt_in` is high -> `o_pending` stays 3, `o_ovf` stays 0. Also test a same-cycle drop and `i_ovf_clr` -> `o_ovf=1`.
- Reset mid-operation: `o_pending=2`, `o_ack_tgl=1`, `o_ovf=1`; assert `i_rst_n=0` for one edge -> all outputs 0 on the next cycle. Also: `i_req_tgl=1` held through reset release -> one event appears 2 edges after release (`SYNC_STAGES=2`).
- Randomized toggle spacing of at least 3 cycles with random `i_evt_rdy` for 10k cycles -> scoreboard: number of `o_ack_tgl` flips plus `o_pending` equals the number of input toggles; `o_ovf` never sets while capacity is not exceeded.
